// File: rtl/saikoro_pkg.sv
// Shared definitions for the electronic-dice roll sequencer, dice counter and bench.
// Holds state encodings and face-value limits.
package saikoro_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROLL   = 2'd1,
    SLOW   = 2'd2,
    SETTLE = 2'd3
  } roll_state_e;

  localparam int FACE_W = 3;

  localparam logic [FACE_W-1:0] FACE_MIN = 3'd1;
  localparam logic [FACE_W-1:0] FACE_MAX = 3'd6;

  function automatic logic [FACE_W-1:0] next_face(input logic [FACE_W-1:0] f);
    return (f == FACE_MAX) ? FACE_MIN : FACE_W'(f + 1'b1);
  endfunction

endpackage

// File: rtl/saikoro_roll_ctrl_gap_timer.sv
// Slow-down pacing for the dice roll: issues SLOW_STEPS pulses with gaps that
// stretch by one cycle after every pulse. The module name is saikoro_gap_timer.
module saikoro_gap_timer #(
  parameter int SLOW_STEPS = 6,
  parameter int BASE_GAP   = 1
) (
  input  logic ck,
  input  logic reset,
  input  logic start,
  input  logic tick,
  output logic pulse,
  output logic last
);

  localparam int GW = $clog2(BASE_GAP + SLOW_STEPS + 1);
  localparam int SW = $clog2(SLOW_STEPS + 1);

  logic [GW-1:0] gap_q, gap_d;
  logic [GW-1:0] gapcnt_q, gapcnt_d;
  logic [SW-1:0] step_q, step_d;
  logic          pulse_q, pulse_d;

  // pulse_q is precomputed one cycle ahead so the strobe leaves a flop.
  always_comb begin
    gap_d    = gap_q;
    gapcnt_d = gapcnt_q;
    step_d   = step_q;
    pulse_d  = 1'b0;
    if (start) begin
      gap_d    = GW'(BASE_GAP);
      gapcnt_d = '0;
      step_d   = '0;
      pulse_d  = (BASE_GAP == 0);
    end else if (tick) begin
      if (pulse_q) begin
        gapcnt_d = '0;
        gap_d    = gap_q + 1'b1;
        step_d   = step_q + 1'b1;
      end else begin
        gapcnt_d = gapcnt_q + 1'b1;
        pulse_d  = (gapcnt_d == gap_q);
      end
    end
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      gap_q    <= '0;
      gapcnt_q <= '0;
      step_q   <= '0;
      pulse_q  <= 1'b0;
    end else begin
      gap_q    <= gap_d;
      gapcnt_q <= gapcnt_d;
      step_q   <= step_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse = pulse_q;
  assign last  = pulse_q && (step_q == SW'(SLOW_STEPS - 1));

endmodule

// File: rtl/saikoro_roll_ctrl.sv
// Dice roll sequencer: spin while the button is held, decelerate, then latch the face.
// Optional SAIKORO_AUTO_STOP_EN forces the slow-down after MAX_ROLL spin cycles.
module saikoro_roll_ctrl
  import saikoro_pkg::*;
#(
  parameter int SLOW_STEPS = 6,
  parameter int BASE_GAP   = 1
`ifdef SAIKORO_AUTO_STOP_EN
  ,
  parameter int MAX_ROLL   = 64
`endif
) (
  input  logic              ck,
  input  logic              reset,
  input  logic              button,
  input  logic [FACE_W-1:0] face,
  output logic              enable,
  output logic              busy,
  output logic              done,
  output logic [FACE_W-1:0] result
);

  roll_state_e       state_q, state_d;
  logic              button_q;
  logic              roll_en_q, roll_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [FACE_W-1:0] result_q, result_d;

  logic press;
  logic roll_stop;
  logic timer_start;
  logic timer_tick;
  logic slow_pulse;
  logic slow_last;

`ifdef SAIKORO_AUTO_STOP_EN
  localparam int RW = (MAX_ROLL > 1) ? $clog2(MAX_ROLL) : 1;
  logic [RW-1:0] roll_cnt_q, roll_cnt_d;

  assign roll_stop = ~button | (roll_cnt_q == RW'(MAX_ROLL - 1));
`else
  assign roll_stop = ~button;
`endif

  // A button still held after a roll cannot re-trigger: only a fresh rising edge counts.
  assign press = button & ~button_q;

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    done_d      = 1'b0;
    timer_start = 1'b0;
    timer_tick  = 1'b0;
`ifdef SAIKORO_AUTO_STOP_EN
    roll_cnt_d  = roll_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (press) begin
          state_d = ROLL;
`ifdef SAIKORO_AUTO_STOP_EN
          roll_cnt_d = '0;
`endif
        end
      end
      ROLL: begin
`ifdef SAIKORO_AUTO_STOP_EN
        roll_cnt_d = roll_cnt_q + 1'b1;
`endif
        if (roll_stop) begin
          state_d     = SLOW;
          timer_start = 1'b1;
        end
      end
      SLOW: begin
        timer_tick = 1'b1;
        if (slow_last) state_d = SETTLE;
      end
      SETTLE: begin
        state_d  = IDLE;
        result_d = face;
        done_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    roll_en_d = (state_d == ROLL);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      button_q   <= 1'b0;
      roll_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
`ifdef SAIKORO_AUTO_STOP_EN
      roll_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      button_q   <= button;
      roll_en_q  <= roll_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
`ifdef SAIKORO_AUTO_STOP_EN
      roll_cnt_q <= roll_cnt_d;
`endif
    end
  end

  saikoro_gap_timer #(
    .SLOW_STEPS(SLOW_STEPS),
    .BASE_GAP  (BASE_GAP)
  ) u_gap_timer (
    .ck   (ck),
    .reset(reset),
    .start(timer_start),
    .tick (timer_tick),
    .pulse(slow_pulse),
    .last (slow_last)
  );

  assign enable = roll_en_q | slow_pulse;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_saikoro_roll_ctrl.sv
// Self-checking bench for saikoro_roll_ctrl with a schedule-based reference model.
// Define SAIKORO_AUTO_STOP_EN to also exercise the auto-stop build with MAX_ROLL=16.
module tb_saikoro_roll_ctrl;
  import saikoro_pkg::*;

  localparam int SLOW_STEPS = 6;
  localparam int BASE_GAP   = 1;
`ifdef SAIKORO_AUTO_STOP_EN
  localparam int MAX_ROLL   = 16;
`endif

  logic              ck     = 1'b0;
  logic              reset  = 1'b1;
  logic              button = 1'b0;
  logic [FACE_W-1:0] face   = FACE_MIN;
  logic              enable;
  logic              busy;
  logic              done;
  logic [FACE_W-1:0] result;

  saikoro_roll_ctrl #(
    .SLOW_STEPS(SLOW_STEPS),
    .BASE_GAP  (BASE_GAP)
`ifdef SAIKORO_AUTO_STOP_EN
    ,
    .MAX_ROLL  (MAX_ROLL)
`endif
  ) dut (
    .ck    (ck),
    .reset (reset),
    .button(button),
    .face  (face),
    .enable(enable),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 ck = ~ck;

  // Dice counter environment: advances on every enable strobe, never reset.
  always @(posedge ck) if (enable) face <= next_face(face);

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: a roll is a span of spin cycles, then a precomputed pulse schedule.
  bit m_roll      = 1'b0;
  int m_roll_len  = 0;
  bit m_sched     = 1'b0;
  int m_pulses[$];
  int m_settle    = 0;
  int m_done      = 0;
  int m_pulse_cnt = 0;
  int m_face      = 1;
  int m_result    = 0;
  bit m_prev_btn  = 1'b0;

  int obs_en       = 0;
  int obs_done_cyc = -1;

  function automatic bit expEnable();
    return m_roll || (m_sched && m_pulses.size() > 0 && m_pulses[0] == cyc);
  endfunction

  function automatic bit expBusy();
    return m_roll || (m_sched && cyc <= m_settle);
  endfunction

  function automatic bit expDone();
    return m_sched && (cyc == m_done);
  endfunction

  function automatic bit rollTimedOut();
`ifdef SAIKORO_AUTO_STOP_EN
    return m_roll_len >= MAX_ROLL;
`else
    return 1'b0;
`endif
  endfunction

  task automatic scheduleSlow(input int last_roll_cyc);
    int t;
    t = last_roll_cyc;
    m_pulses.delete();
    for (int k = 0; k < SLOW_STEPS; k++) begin
      t = t + BASE_GAP + k + 1;
      m_pulses.push_back(t);
    end
    m_settle    = t + 1;
    m_done      = t + 2;
    m_sched     = 1'b1;
    m_pulse_cnt = 0;
  endtask

  task automatic modelStep(input bit b);
    bit en;
    bit idle;
    en   = expEnable();
    idle = !m_roll && !(m_sched && cyc <= m_settle);
    if (m_sched && cyc == m_settle) m_result = m_face;
    if (en) m_face = (m_face % 6) + 1;
    if (m_sched && m_pulses.size() > 0 && m_pulses[0] == cyc) begin
      void'(m_pulses.pop_front());
      m_pulse_cnt++;
    end
    if (m_sched && cyc == m_done) m_sched = 1'b0;
    if (m_roll) begin
      m_roll_len++;
      if (!b || rollTimedOut()) begin
        m_roll = 1'b0;
        scheduleSlow(cyc);
      end
    end else if (idle && b && !m_prev_btn) begin
      m_roll     = 1'b1;
      m_roll_len = 0;
    end
    m_prev_btn = b;
  endtask

  task automatic checkSig(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput();
    checkSig("enable", 8'(enable), 8'(expEnable()));
    checkSig("busy",   8'(busy),   8'(expBusy()));
    checkSig("done",   8'(done),   8'(expDone()));
    checkSig("result", 8'(result), 8'(m_result));
  endtask

  // One clock cycle: check the outputs mid-cycle, then drive this cycle's button level.
  task automatic applyStimulus(input bit b);
    @(negedge ck);
    checkOutput();
    if (enable === 1'b1) obs_en++;
    if (done === 1'b1) obs_done_cyc = cyc;
    button = b;
    modelStep(b);
    cyc++;
  endtask

  task automatic doReset();
    @(posedge ck);
    #2;
    reset  = 1'b0;
    button = 1'b0;
    #1;
    checkSig("rst_enable", 8'(enable), 8'd0);
    checkSig("rst_busy",   8'(busy),   8'd0);
    checkSig("rst_done",   8'(done),   8'd0);
    checkSig("rst_result", 8'(result), 8'd0);
    repeat (2) @(negedge ck);
    reset       = 1'b1;
    m_roll      = 1'b0;
    m_roll_len  = 0;
    m_sched     = 1'b0;
    m_pulses.delete();
    m_pulse_cnt = 0;
    m_result    = 0;
    m_prev_btn  = 1'b0;
  endtask

  initial begin
    int start_cyc;
    int end_cyc;
    bit v;
    int len;

    doReset();
    repeat (20) applyStimulus(1'b0);
    checkSig("idle_busy",   8'(busy),   8'd0);
    checkSig("idle_result", 8'(result), 8'd0);

    $display("[TB] basic roll: 10 spin cycles from face 1");
    obs_en = 0;
    obs_done_cyc = -1;
    start_cyc = cyc;
    repeat (10) applyStimulus(1'b1);
    repeat (42) applyStimulus(1'b0);
    checkSig("pin_enable_count", 8'(obs_en), 8'd16);
    checkSig("pin_done_offset",  8'(obs_done_cyc - start_cyc), 8'd39);
    checkSig("pin_result",       8'(result), 8'd5);

    $display("[TB] reset during slow-down after third pulse");
    repeat (5) applyStimulus(1'b1);
    applyStimulus(1'b0);
    for (int i = 0; i < 60 && !(m_sched && m_pulse_cnt >= 3); i++) applyStimulus(1'b0);
    checks++;
    if (!(m_sched && m_pulse_cnt == 3)) begin
      errors++;
      $display("[TB] FAIL third_pulse_wait: pulses %0d, expected 3", m_pulse_cnt);
    end
    doReset();
    repeat (10) applyStimulus(1'b0);
    checkSig("post_reset_busy",   8'(busy),   8'd0);
    checkSig("post_reset_result", 8'(result), 8'd0);

    $display("[TB] button toggling during slow-down");
    repeat (4) applyStimulus(1'b1);
    applyStimulus(1'b0);
    end_cyc = cyc - 1;
    obs_en = 0;
    obs_done_cyc = -1;
    repeat (27) applyStimulus(1'($urandom_range(0, 1)));
    repeat (6) applyStimulus(1'b0);
    checkSig("pin_slow_pulses", 8'(obs_en), 8'd6);
    checkSig("pin_slow_done",   8'(obs_done_cyc - end_cyc), 8'd29);

    $display("[TB] button held through done, then re-pressed");
    repeat (3) applyStimulus(1'b1);
    applyStimulus(1'b0);
    repeat (40) applyStimulus(1'b1);
    checkSig("held_no_reroll", 8'(busy), 8'd0);
    repeat (2) applyStimulus(1'b0);
    repeat (3) applyStimulus(1'b1);
    repeat (36) applyStimulus(1'b0);

`ifdef SAIKORO_AUTO_STOP_EN
    $display("[TB] auto-stop: button held 100 cycles");
    obs_en = 0;
    repeat (100) applyStimulus(1'b1);
    checkSig("pin_autostop_enables", 8'(obs_en), 8'd22);
    checkSig("pin_autostop_idle",    8'(busy),   8'd0);
    repeat (3) applyStimulus(1'b0);
`endif

    $display("[TB] random button bursts");
    for (int i = 0; i < 40; i++) begin
      v   = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      repeat (len) applyStimulus(v);
    end
    repeat (40) applyStimulus(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/saikoro_roll_ctrl.md
Name: saikoro_roll_ctrl

Overview:
Sequencer for the electronic-dice counter (1..6 face counter with 7-segment lamp decode).
- Converts a single player button into a realistic roll: free-running spin while the button is held, then a decelerating slow-down of exactly SLOW_STEPS advances, then stop.
- Drives the dice counter's enable input and reads back its face value.
- Latches the final face and flags completion to downstream game logic.

Parameters:
- SLOW_STEPS, 6: number of enable pulses issued during slow-down.
- BASE_GAP, 1: idle cycles before the first slow-down pulse; each later gap is one cycle longer.
- MAX_ROLL, 64: ROLL timeout in cycles; used only with SAIKORO_AUTO_STOP_EN.

Ports:
- ck  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- button  in  1  player button, already synchronised and debounced; level.
- face  in  3  current dice value from the counter, 1..6.
- enable  out  1  advance strobe to the dice counter.
- busy  out  1  high in ROLL, SLOW and SETTLE.
- done  out  1  one-cycle pulse when result is updated.
- result  out  3  last latched face; 0 = no roll yet.

Behaviour:
Reset state (reset=0, asynchronous):
- State is IDLE.
- enable=0, busy=0, done=0, result=0; all counters 0.
- Reset asserted mid-roll aborts immediately. result is cleared, not preserved.

Edge detection:
- press = button & ~button_q, where button_q is a register reset to 0.

States:
- IDLE: enable=0. press -> ROLL. A level-high button with no edge is ignored.
- ROLL: enable=1 every cycle.
  - button=0 sampled -> SLOW, with gap=BASE_GAP, gapcnt=0, step=0.
  - The enable of the transition cycle is still 1.
- SLOW: enable=1 only in the cycle where gapcnt==gap; otherwise 0.
  - On a pulse cycle: gapcnt<=0, gap<=gap+1, step<=step+1.
  - On other cycles: gapcnt<=gapcnt+1.
  - When the pulse with step==SLOW_STEPS-1 issues -> SETTLE.
  - Button activity in SLOW is ignored.
- SETTLE: one cycle, enable=0. This lets the counter update from the last pulse.
  - On the closing edge: result<=face (captured verbatim, no range check), done<=1 for exactly the next cycle, state -> IDLE.

Timing and widths:
- Slow-down totals: exactly SLOW_STEPS pulses in sum over k=0..SLOW_STEPS-1 of (BASE_GAP+k+1) cycles. Defaults give 27 cycles.
- done is asserted 1 cycle after SETTLE. result is valid in the same cycle as done and is held until the next done or reset.
- A press in the done cycle is accepted: IDLE sees it, and the roll starts the next cycle.
- gap/gapcnt width: clog2(BASE_GAP+SLOW_STEPS+1).
- step width: clog2(SLOW_STEPS+1).
- No wrap is possible within the legal parameter range. SLOW_STEPS>=1 and BASE_GAP>=0 are required.

Optional Feature:
Macro SAIKORO_AUTO_STOP_EN.
- Defined: a roll counter increments each ROLL cycle. When it reaches MAX_ROLL-1, the block enters SLOW even if button is still 1.
  - It then requires button=0 before any new press is recognised, because the edge detector naturally handles this.
  - The roll counter clears on entering ROLL.
- Undefined: ROLL lasts as long as button is held. No roll counter or MAX_ROLL logic is synthesised.

Decomposition:
Shared package/header saikoro_pkg:
- state encodings (IDLE, ROLL, SLOW, SETTLE);
- FACE_W=3;
- FACE_MIN=1, FACE_MAX=6.
These are shared with the dice counter and the bench.

One sub-module, saikoro_gap_timer:
- holds gap, gapcnt and step;
- inputs: start, tick;
- outputs: pulse, last.
The FSM stays in saikoro_roll_ctrl.

Test Plan:
- Reset release, no button, 20 cycles -> enable=0, busy=0, done never asserted, result=0.
- Button high 10 cycles then low, dice counter starting at 1 -> 10 consecutive enable cycles in ROLL, then exactly 6 SLOW pulses at gaps 2,3,4,5,6,7 cycles. done 1 cycle after SETTLE; result equals the counter value.
- Reset driven low in the middle of SLOW (after 3rd pulse) -> enable, busy and result drop to 0 asynchronously. After release the block idles until a fresh press.
- Button toggled during SLOW -> pulse count and spacing unchanged (6 pulses, 27 cycles), no restart.
- Button held high through done, then pressed again -> no second roll until button low then high; second done updates result and the first value is held meanwhile.
- With SAIKORO_AUTO_STOP_EN, MAX_ROLL=16, button held 100 cycles -> exactly 16 ROLL enable cycles, then slow-down, done. No further roll while button stays high.
